// File: rtl/alu_arbiter_if.sv
// Request/response/ALU bundle shared by two requesters and one arbitrated combinational ALU.
// Latency: none (wires only).
// Backpressure: valid/ready on both the request and response channels of each requester.
//
// Ports (as seen by the arbiter, modport slave):
//   i_reqN_valid/op/data_1/data_2 in, o_reqN_ready out   -- requester N request channel
//   o_rspN_valid/result out, i_rspN_ready in             -- requester N response channel
//   o_alu_op/data_1/data_2 out, i_alu_result in          -- shared combinational ALU
interface alu_arbiter_if #(
    parameter int XLEN   = 32,
    parameter int ALUOPS = 4
);
    logic              i_req0_valid;
    logic              o_req0_ready;
    logic [ALUOPS-1:0] i_req0_op;
    logic [XLEN-1:0]   i_req0_data_1;
    logic [XLEN-1:0]   i_req0_data_2;

    logic              i_req1_valid;
    logic              o_req1_ready;
    logic [ALUOPS-1:0] i_req1_op;
    logic [XLEN-1:0]   i_req1_data_1;
    logic [XLEN-1:0]   i_req1_data_2;

    logic              o_rsp0_valid;
    logic              i_rsp0_ready;
    logic [XLEN-1:0]   o_rsp0_result;

    logic              o_rsp1_valid;
    logic              i_rsp1_ready;
    logic [XLEN-1:0]   o_rsp1_result;

    logic [ALUOPS-1:0] o_alu_op;
    logic [XLEN-1:0]   o_alu_data_1;
    logic [XLEN-1:0]   o_alu_data_2;
    logic [XLEN-1:0]   i_alu_result;

    modport slave (
        input  i_req0_valid, i_req0_op, i_req0_data_1, i_req0_data_2,
        input  i_req1_valid, i_req1_op, i_req1_data_1, i_req1_data_2,
        input  i_rsp0_ready, i_rsp1_ready, i_alu_result,
        output o_req0_ready, o_req1_ready,
        output o_rsp0_valid, o_rsp0_result, o_rsp1_valid, o_rsp1_result,
        output o_alu_op, o_alu_data_1, o_alu_data_2
    );

    modport master (
        output i_req0_valid, i_req0_op, i_req0_data_1, i_req0_data_2,
        output i_req1_valid, i_req1_op, i_req1_data_1, i_req1_data_2,
        output i_rsp0_ready, i_rsp1_ready, i_alu_result,
        input  o_req0_ready, o_req1_ready,
        input  o_rsp0_valid, o_rsp0_result, o_rsp1_valid, o_rsp1_result,
        input  o_alu_op, o_alu_data_1, o_alu_data_2
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, one result slot.
// Latency: 1 cycle from request acceptance to response valid; one op per cycle sustained.
// Backpressure: request ready only when the slot is empty or drains this cycle; stalled response holds.
//
// Ports: i_clk, i_rst_n (async active-low); bus (alu_arbiter_if.slave) carries both request
// channels, both response channels and the ALU drive/result; o_busy = response held;
// o_op_count = completed response handshakes (wraps).
module alu_arbiter #(
    parameter int XLEN   = 32,
    parameter int ALUOPS = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    alu_arbiter_if.slave bus,
    output logic         o_busy,
    output logic [31:0]  o_op_count
);

    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              own_q, own_d;
    logic              rr_q, rr_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [31:0]       op_count_q, op_count_d;

    logic              grant;
    logic              rsp_hs;
    logic              free;
    logic              accept;
    logic [ALUOPS-1:0] alu_op;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            own_q      <= 1'b0;
            rr_q       <= 1'b0;
            result_q   <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            own_q      <= own_d;
            rr_q       <= rr_d;
            result_q   <= result_d;
            op_count_q <= op_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        rr_d       = rr_q;
        result_d   = result_q;
        op_count_d = op_count_q;

        // A lone requester wins outright; contention or silence falls back to the pointer,
        // so the ALU always sees some requester's operands.
        grant = rr_q;
        if (bus.i_req0_valid && !bus.i_req1_valid) begin
            grant = 1'b0;
        end else if (!bus.i_req0_valid && bus.i_req1_valid) begin
            grant = 1'b1;
        end

        // Only the owner's ready can complete the held response.
        rsp_hs = (state_q == RESP) && (own_q ? bus.i_rsp1_ready : bus.i_rsp0_ready);
        free   = (state_q == IDLE) || rsp_hs;

        bus.o_req0_ready = free && !grant;
        bus.o_req1_ready = free && grant;
        accept = (bus.o_req0_ready && bus.i_req0_valid) || (bus.o_req1_ready && bus.i_req1_valid);

        alu_op           = grant ? bus.i_req1_op     : bus.i_req0_op;
        bus.o_alu_op     = alu_op;
        bus.o_alu_data_1 = grant ? bus.i_req1_data_1 : bus.i_req0_data_1;
        bus.o_alu_data_2 = grant ? bus.i_req1_data_2 : bus.i_req0_data_2;

        if (rsp_hs) begin
            op_count_d = op_count_q + 32'd1;
        end

        // A same-cycle acceptance refills the slot behind a draining response.
        if (accept) begin
            state_d  = RESP;
            own_d    = grant;
            rr_d     = !grant;
            result_d = bus.i_alu_result;
        end else if (rsp_hs) begin
            state_d  = IDLE;
        end
    end

    always_comb begin
        bus.o_rsp0_valid  = (state_q == RESP) && !own_q;
        bus.o_rsp1_valid  = (state_q == RESP) && own_q;
        bus.o_rsp0_result = bus.o_rsp0_valid ? result_q : '0;
        bus.o_rsp1_result = bus.o_rsp1_valid ? result_q : '0;
    end

    assign o_busy     = (state_q == RESP);
    assign o_op_count = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural combinational ALU on the shared port.
// Latency: checks 1-cycle response latency and same-cycle readies.
// Backpressure: exercises stalled responses, contention, reset mid-response and counter wrap.
module tb_alu_arbiter;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    logic        i_clk;
    logic        i_rst_n;
    logic        o_busy;
    logic [31:0] o_op_count;

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter_if #(.XLEN(32), .ALUOPS(4)) bus ();

    alu_arbiter #(.XLEN(32), .ALUOPS(4)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .bus        (bus),
        .o_busy     (o_busy),
        .o_op_count (o_op_count)
    );

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLL:  return a << b[4:0];
            OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: return {31'd0, a < b};
            OP_XOR:  return a ^ b;
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return 32'($signed(a) >>> b[4:0]);
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            default: return 32'd0;
        endcase
    endfunction

    assign bus.i_alu_result = alu_f(bus.o_alu_op, bus.o_alu_data_1, bus.o_alu_data_2);

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    initial begin
        i_rst_n           = 1'b0;
        bus.i_req0_valid  = 1'b0;
        bus.i_req0_op     = OP_ADD;
        bus.i_req0_data_1 = '0;
        bus.i_req0_data_2 = '0;
        bus.i_req1_valid  = 1'b0;
        bus.i_req1_op     = OP_ADD;
        bus.i_req1_data_1 = '0;
        bus.i_req1_data_2 = '0;
        bus.i_rsp0_ready  = 1'b0;
        bus.i_rsp1_ready  = 1'b0;

        // Reset state
        repeat (2) @(negedge i_clk);
        #1;
        check_eq("rst_rsp0_valid", 32'(bus.o_rsp0_valid), 0);
        check_eq("rst_rsp1_valid", 32'(bus.o_rsp1_valid), 0);
        check_eq("rst_busy",       32'(o_busy), 0);
        check_eq("rst_op_count",   o_op_count, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Single ADD right after reset release
        bus.i_req0_valid  = 1'b1;
        bus.i_req0_op     = OP_ADD;
        bus.i_req0_data_1 = 32'd5;
        bus.i_req0_data_2 = 32'd7;
        bus.i_rsp0_ready  = 1'b1;
        #1;
        check_eq("add_req0_ready", 32'(bus.o_req0_ready), 1);
        check_eq("add_req1_ready", 32'(bus.o_req1_ready), 0);
        check_eq("add_alu_op",     32'(bus.o_alu_op), 32'(OP_ADD));
        check_eq("add_alu_d1",     bus.o_alu_data_1, 5);
        check_eq("add_alu_d2",     bus.o_alu_data_2, 7);
        @(negedge i_clk);
        check_eq("add_rsp0_valid",  32'(bus.o_rsp0_valid), 1);
        check_eq("add_rsp0_result", bus.o_rsp0_result, 12);
        check_eq("add_rsp1_valid",  32'(bus.o_rsp1_valid), 0);
        check_eq("add_busy",        32'(o_busy), 1);
        check_eq("add_count_pre",   o_op_count, 0);
        bus.i_req0_valid = 1'b0;
        @(negedge i_clk);
        check_eq("add_count",       o_op_count, 1);
        check_eq("add_rsp0_gone",   32'(bus.o_rsp0_valid), 0);
        check_eq("add_result_zero", bus.o_rsp0_result, 0);
        check_eq("add_idle",        32'(o_busy), 0);

        // Contention after reset: requester 0 first, then 1
        i_rst_n = 1'b0;
        #1;
        i_rst_n = 1'b1;
        check_eq("rr_rst_count", o_op_count, 0);
        bus.i_req0_valid  = 1'b1;
        bus.i_req0_op     = OP_SUB;
        bus.i_req0_data_1 = 32'd10;
        bus.i_req0_data_2 = 32'd3;
        bus.i_req1_valid  = 1'b1;
        bus.i_req1_op     = OP_XOR;
        bus.i_req1_data_1 = 32'hF0;
        bus.i_req1_data_2 = 32'h0F;
        bus.i_rsp0_ready  = 1'b1;
        bus.i_rsp1_ready  = 1'b1;
        #1;
        check_eq("rr_req0_ready", 32'(bus.o_req0_ready), 1);
        check_eq("rr_req1_ready", 32'(bus.o_req1_ready), 0);
        @(negedge i_clk);
        check_eq("rr_rsp0_valid",  32'(bus.o_rsp0_valid), 1);
        check_eq("rr_rsp0_result", bus.o_rsp0_result, 7);
        bus.i_req0_valid = 1'b0;
        #1;
        check_eq("rr_req1_ready2", 32'(bus.o_req1_ready), 1);
        @(negedge i_clk);
        check_eq("rr_rsp1_valid",  32'(bus.o_rsp1_valid), 1);
        check_eq("rr_rsp1_result", bus.o_rsp1_result, 32'hFF);
        check_eq("rr_rsp0_done",   32'(bus.o_rsp0_valid), 0);
        check_eq("rr_count1",      o_op_count, 1);
        bus.i_req1_valid = 1'b0;
        #1;
        // Nobody valid: ALU follows the pointer, which must be back on requester 0
        check_eq("rr_ptr_back0", 32'(bus.o_alu_op), 32'(OP_SUB));
        @(negedge i_clk);
        check_eq("rr_count2", o_op_count, 2);
        check_eq("rr_idle",   32'(o_busy), 0);

        // Stalled response holds everything
        bus.i_req1_valid  = 1'b1;
        bus.i_req1_op     = OP_SLT;
        bus.i_req1_data_1 = 32'hFFFF_FFFF;
        bus.i_req1_data_2 = 32'd1;
        bus.i_rsp1_ready  = 1'b0;
        bus.i_rsp0_ready  = 1'b1;
        #1;
        check_eq("stall_req1_ready", 32'(bus.o_req1_ready), 1);
        @(negedge i_clk);
        bus.i_req0_valid  = 1'b1;
        bus.i_req0_op     = OP_ADD;
        bus.i_req0_data_1 = 32'd1;
        bus.i_req0_data_2 = 32'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("stall_rsp1_valid",  32'(bus.o_rsp1_valid), 1);
            check_eq("stall_rsp1_result", bus.o_rsp1_result, 1);
            check_eq("stall_req0_ready",  32'(bus.o_req0_ready), 0);
            check_eq("stall_req1_ready0", 32'(bus.o_req1_ready), 0);
            check_eq("stall_count",       o_op_count, 2);
            @(negedge i_clk);
        end
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        bus.i_rsp1_ready = 1'b1;
        @(negedge i_clk);
        check_eq("stall_count_done", o_op_count, 3);
        check_eq("stall_rsp1_gone",  32'(bus.o_rsp1_valid), 0);

        // Back-to-back alternation, one op per cycle
        bus.i_req0_valid  = 1'b1;
        bus.i_req0_op     = OP_ADD;
        bus.i_req0_data_1 = 32'd1;
        bus.i_req0_data_2 = 32'd1;
        bus.i_req1_valid  = 1'b1;
        bus.i_req1_op     = OP_OR;
        bus.i_req1_data_1 = 32'h10;
        bus.i_req1_data_2 = 32'h01;
        bus.i_rsp0_ready  = 1'b1;
        bus.i_rsp1_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("b2b_req0_ready", 32'(bus.o_req0_ready), 32'((i % 2) == 0));
            check_eq("b2b_req1_ready", 32'(bus.o_req1_ready), 32'((i % 2) == 1));
            @(negedge i_clk);
            if ((i % 2) == 0) begin
                check_eq("b2b_rsp0_valid",  32'(bus.o_rsp0_valid), 1);
                check_eq("b2b_rsp0_result", bus.o_rsp0_result, 2);
            end else begin
                check_eq("b2b_rsp1_valid",  32'(bus.o_rsp1_valid), 1);
                check_eq("b2b_rsp1_result", bus.o_rsp1_result, 32'h11);
            end
            check_eq("b2b_count", o_op_count, 32'(3 + i));
        end
        bus.i_req0_valid = 1'b0;
        bus.i_req1_valid = 1'b0;
        @(negedge i_clk);
        check_eq("b2b_count_end", o_op_count, 7);
        check_eq("b2b_idle",      32'(o_busy), 0);

        // Reset while a response is held
        bus.i_req0_valid  = 1'b1;
        bus.i_req0_op     = OP_ADD;
        bus.i_req0_data_1 = 32'd2;
        bus.i_req0_data_2 = 32'd2;
        @(negedge i_clk);
        check_eq("arst_rsp0_valid_pre", 32'(bus.o_rsp0_valid), 1);
        bus.i_req0_valid = 1'b0;
        bus.i_rsp0_ready = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        check_eq("arst_rsp0_valid", 32'(bus.o_rsp0_valid), 0);
        check_eq("arst_rsp0_result", bus.o_rsp0_result, 0);
        check_eq("arst_count",      o_op_count, 0);
        check_eq("arst_busy",       32'(o_busy), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        bus.i_rsp0_ready = 1'b1;
        @(negedge i_clk);
        check_eq("arst_no_rsp",      32'(bus.o_rsp0_valid), 0);
        check_eq("arst_count_after", o_op_count, 0);

        // Counter wrap
        bus.i_req1_valid  = 1'b1;
        bus.i_req1_op     = OP_AND;
        bus.i_req1_data_1 = 32'hFF;
        bus.i_req1_data_2 = 32'h0F;
        bus.i_rsp1_ready  = 1'b0;
        @(negedge i_clk);
        bus.i_req1_valid = 1'b0;
        force dut.op_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.op_count_q;
        #1;
        check_eq("wrap_preload",    o_op_count, 32'hFFFF_FFFF);
        check_eq("wrap_rsp1_result", bus.o_rsp1_result, 32'h0F);
        bus.i_rsp1_ready = 1'b1;
        @(negedge i_clk);
        check_eq("wrap_count",     o_op_count, 32'h0000_0000);
        check_eq("wrap_rsp1_gone", 32'(bus.o_rsp1_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
